// File: rtl/sdrc_app_arb.sv
// Two-port round-robin arbiter in front of the SDRAM controller application port.
// Ports: p0_*/p1_* requester sides, app_* core side, sdram_clk/sdram_resetn.
module sdrc_app_arb #(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic              p0_req,
  input  logic [APP_AW-1:0] p0_req_addr,
  input  logic [bl-1:0]     p0_req_len,
  input  logic              p0_req_wr_n,
  output logic              p0_req_ack,
  output logic              p0_gnt,
  input  logic [dw-1:0]     p0_wr_data,
  input  logic [dw/8-1:0]   p0_wr_en_n,
  output logic              p0_wr_next,
  output logic              p0_rd_valid,
  output logic              p0_last_rd,
  output logic [dw-1:0]     p0_rd_data,
  input  logic              p1_req,
  input  logic [APP_AW-1:0] p1_req_addr,
  input  logic [bl-1:0]     p1_req_len,
  input  logic              p1_req_wr_n,
  output logic              p1_req_ack,
  output logic              p1_gnt,
  input  logic [dw-1:0]     p1_wr_data,
  input  logic [dw/8-1:0]   p1_wr_en_n,
  output logic              p1_wr_next,
  output logic              p1_rd_valid,
  output logic              p1_last_rd,
  output logic [dw-1:0]     p1_rd_data,
  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [bl-1:0]     app_req_len,
  output logic              app_req_wr_n,
  input  logic              app_req_ack,
  output logic [dw-1:0]     app_wr_data,
  output logic [dw/8-1:0]   app_wr_en_n,
  input  logic              app_wr_next_req,
  input  logic              app_last_wr,
  input  logic              app_rd_valid,
  input  logic              app_last_rd,
  input  logic [dw-1:0]     app_rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   owner, owner_nx;
  logic   last_gnt, last_nx;
  logic   cap, sel;
  logic   busy, in_wr, in_rd;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_gnt;
    cap      = 1'b0;
    sel      = 1'b0;
    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          // tie goes to the port that did not own the last burst
          sel      = (p0_req && p1_req) ? ~last_gnt : p1_req;
          cap      = 1'b1;
          owner_nx = sel;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (app_req_ack)
          state_nx = app_req_wr_n ? RD : WR;
      end
      WR: begin
        if (app_wr_next_req && app_last_wr) begin
          state_nx = IDLE;
          last_nx  = owner;
        end
      end
      RD: begin
        if (app_rd_valid && app_last_rd) begin
          state_nx = IDLE;
          last_nx  = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_gnt     <= 1'b1;
      app_req_addr <= '0;
      app_req_len  <= '0;
      app_req_wr_n <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last_gnt <= last_nx;
      if (cap) begin
        app_req_addr <= sel ? p1_req_addr : p0_req_addr;
        app_req_len  <= sel ? p1_req_len  : p0_req_len;
        app_req_wr_n <= sel ? p1_req_wr_n : p0_req_wr_n;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign in_wr = (state == WR);
  assign in_rd = (state == RD);

  assign app_req = (state == REQ);
  assign p0_gnt  = busy & ~owner;
  assign p1_gnt  = busy &  owner;

  assign p0_req_ack = app_req & app_req_ack & ~owner;
  assign p1_req_ack = app_req & app_req_ack &  owner;

  assign p0_wr_next = in_wr & ~owner & app_wr_next_req;
  assign p1_wr_next = in_wr &  owner & app_wr_next_req;

  assign app_wr_data = !busy ? '0 : owner ? p1_wr_data : p0_wr_data;
  assign app_wr_en_n = !busy ? '1 : owner ? p1_wr_en_n : p0_wr_en_n;

  assign p0_rd_valid = in_rd & ~owner & app_rd_valid;
  assign p1_rd_valid = in_rd &  owner & app_rd_valid;
  assign p0_last_rd  = in_rd & ~owner & app_last_rd;
  assign p1_last_rd  = in_rd &  owner & app_last_rd;

  assign p0_rd_data = app_rd_data;
  assign p1_rd_data = app_rd_data;

endmodule
